regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the register file's single write port between the in-order pipeline writeback (port A) and a variable-latency side unit such as the multi-cycle multiplier (port B). Port A has priority. Port B results queue in a small FIFO and drain into idle writeback slots. Sustained starvation of port B raises a pipeline stall request. Outputs are registered and drive the register file write enable, address (into the 5-to-32 write-enable decoder) and data directly.

## Interface
- DATA_W, 64: write data width.
- FIFO_DEPTH, 2: port B queue entries; power of two, ≥2.
- STARVE_LIMIT, 4: consecutive cycles a non-empty FIFO may lose before stall_req asserts; ≥1.

- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- a_wr_en  in  1  pipeline writeback valid; no handshake; must be 0 while stall_req=1.
- a_wr_addr  in  5  pipeline destination register.
- a_wr_data  in  DATA_W  pipeline result.
- b_valid  in  1  side-unit result valid.
- b_ready  out  1  FIFO can accept; registered.
- b_addr  in  5  side-unit destination register.
- b_data  in  DATA_W  side-unit result.
- stall_req  out  1  freeze pipeline writeback; registered.
- rf_wr_en  out  1  register file write enable.
- rf_wr_addr  out  5  register file write address.
- rf_wr_data  out  DATA_W  register file write data.
- b_pending  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- proto_err  out  1  sticky; set when a_wr_en=1 while stall_req=1.

## Operation
- Writes to X31 (XZR) are discarded from either port: A is treated as idle; B entries are popped without asserting rf_wr_en.
- Push: b_valid && b_ready. Popped entries are never visible in the cycle they are pushed (no bypass).
- FSM states are NORMAL and STALL; reset state is NORMAL.
- NORMAL, per-cycle select:
  - A is valid and its address is not 31: write A.
  - Otherwise, FIFO is non-empty: pop the head and write it.
  - Otherwise: no write.
- Starve counter:
  - Increments each cycle in which the FIFO is non-empty and A wins.
  - Clears on any pop or when the FIFO is empty.
  - Reaching STARVE_LIMIT moves the FSM to STALL.
- STALL:
  - stall_req=1 and B has priority.
  - After exactly one pop, the FSM returns to NORMAL and the counter clears.
- A request in STALL violates protocol. It is dropped and proto_err is set; proto_err clears only on reset.
- Write ordering equals grant order. Same-register hazards between A and queued B entries are the hazard unit's responsibility.

## Timing
- Latency from A request to rf_wr_*: 1 cycle.
- Minimum latency from B push to rf_wr_*: 2 cycles.
- b_ready is registered as next-cycle (occupancy < FIFO_DEPTH). A simultaneous push and pop when full is impossible, because b_ready is already low.
- stall_req:
  - Rises the cycle after the counter reaches STARVE_LIMIT.
  - Falls the cycle after the STALL pop.
  - Minimum width is 1 cycle.
- Reset, asynchronous and taking effect mid-operation:
  - Outputs: rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, stall_req=0, b_ready=0, b_pending=0, proto_err=0.
  - Internal: FIFO emptied (queued entries lost), counter=0, FSM=NORMAL.
  - b_ready rises on the first clk edge after reset_n deasserts.

## Structure
- Package regfile_pkg:
  - XZR_ADDR = 5'd31.
  - Enum arb_state_t {NORMAL, STALL}.
  - Struct wb_req_t {addr[4:0], data[DATA_W-1:0]}.
- One sub-module, wb_fifo: a synchronous FIFO of wb_req_t with push/pop/count.
- All other logic (select mux, counter, FSM, output registers) is flat in regfile_wb_arbiter.

## Test plan
- A only, back-to-back: X1=0x11, X2=0x22 in consecutive cycles → rf_wr_en high for two cycles with addr 1, 2 one cycle later; b_pending=0.
- B into idle slot: b push X5=0xAB with A idle → rf_wr_en, addr 5, data 0xAB exactly 2 cycles after the push; b_pending returns to 0.
- XZR discard: A to X31, then B to X31 → rf_wr_en stays 0 throughout; the B entry is popped and b_pending returns to 0.
- Starvation: one B entry queued with A writing every cycle, STARVE_LIMIT=4 → stall_req high for one cycle after 4 lost cycles. The bench holds a_wr_en=0; the B entry is written; stall_req then falls.
- Full FIFO: push 2 entries while A is busy → b_ready=0. A third b_valid is not accepted until a pop.
- Async reset mid-operation: reset_n low with 2 entries queued and stall_req=1 → all outputs 0 immediately, no stale write after release, b_ready=1 one edge later.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_pkg;

  localparam logic [4:0]  XZR_ADDR  = 5'd31;
  localparam int unsigned WB_DATA_W = 64;

  typedef enum logic [0:0] {
    NORMAL,
    STALL
  } arb_state_t;

  typedef struct packed {
    logic [4:0]           addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests; head is valid whenever count is non-zero.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  wb_req_t                push_req,
  input  logic                   pop,
  output wb_req_t                head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  wb_req_t         mem [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic            push_ok, pop_ok;

  assign push_ok = push && (count_q != CntW'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= push_req;
  end

  assign head  = mem[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback (A, priority)
// and a queued side unit (B), with a starvation-triggered pipeline stall.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        a_wr_en,
  input  logic [4:0]                  a_wr_addr,
  input  logic [DATA_W-1:0]           a_wr_data,
  input  logic                        b_valid,
  output logic                        b_ready,
  input  logic [4:0]                  b_addr,
  input  logic [DATA_W-1:0]           b_data,
  output logic                        stall_req,
  output logic                        rf_wr_en,
  output logic [4:0]                  rf_wr_addr,
  output logic [DATA_W-1:0]           rf_wr_data,
  output logic [$clog2(FIFO_DEPTH):0] b_pending,
  output logic                        proto_err
);

  localparam int unsigned OccW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  arb_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [OccW-1:0] occ, occ_next;
  wb_req_t         push_req, head;
  logic            push, pop, fifo_empty, a_valid, a_win;
  logic            wr_en_d;
  logic [4:0]      wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;

  assign push          = b_valid && b_ready;
  assign push_req.addr = b_addr;
  assign push_req.data = WB_DATA_W'(b_data);
  assign fifo_empty    = (occ == '0);
  assign a_valid       = a_wr_en && (a_wr_addr != XZR_ADDR);
  assign occ_next      = occ + OccW'(push) - OccW'(pop);

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_req (push_req),
    .pop      (pop),
    .head     (head),
    .count    (occ)
  );

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    a_win     = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = rf_wr_addr;
    wr_data_d = rf_wr_data;
    unique case (state_q)
      NORMAL: begin
        if (a_valid) begin
          a_win     = 1'b1;
          wr_en_d   = 1'b1;
          wr_addr_d = a_wr_addr;
          wr_data_d = a_wr_data;
        end else if (!fifo_empty) begin
          pop = 1'b1;
        end
      end
      STALL: begin
        // A is ignored here; a request in this state only flags proto_err.
        pop     = !fifo_empty;
        state_d = NORMAL;
      end
      default: state_d = NORMAL;
    endcase

    // XZR entries are popped but never reach the register file.
    if (pop && (head.addr != XZR_ADDR)) begin
      wr_en_d   = 1'b1;
      wr_addr_d = head.addr;
      wr_data_d = DATA_W'(head.data);
    end

    cnt_d = cnt_q;
    if (pop || fifo_empty) cnt_d = '0;
    else if (a_win)        cnt_d = cnt_q + 1'b1;

    if ((state_q == NORMAL) && (cnt_d == CntW'(STARVE_LIMIT))) state_d = STALL;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= NORMAL;
      cnt_q      <= '0;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      stall_req  <= 1'b0;
      b_ready    <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rf_wr_en   <= wr_en_d;
      rf_wr_addr <= wr_addr_d;
      rf_wr_data <= wr_data_d;
      stall_req  <= (state_d == STALL);
      b_ready    <= (occ_next < OccW'(FIFO_DEPTH));
      if (a_wr_en && stall_req) proto_err <= 1'b1;
    end
  end

  assign b_pending = occ;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (DATA_W=64, depth 2, limit 4).
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset_n;
  logic        a_wr_en;
  logic [4:0]  a_wr_addr;
  logic [63:0] a_wr_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [63:0] b_data;
  logic        stall_req;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [63:0] rf_wr_data;
  logic [1:0]  b_pending;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(
    .DATA_W       (64),
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .a_wr_en    (a_wr_en),
    .a_wr_addr  (a_wr_addr),
    .a_wr_data  (a_wr_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .stall_req  (stall_req),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .b_pending  (b_pending),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic en, input logic [4:0] addr, input logic [63:0] data);
    a_wr_en   = en;
    a_wr_addr = addr;
    a_wr_data = data;
  endtask

  task automatic set_b(input logic v, input logic [4:0] addr, input logic [63:0] data);
    b_valid = v;
    b_addr  = addr;
    b_data  = data;
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [4:0] addr,
                        input logic [63:0] data);
    chk({tag, "_en"}, rf_wr_en, en);
    if (en) begin
      chk({tag, "_addr"}, rf_wr_addr, addr);
      chk({tag, "_data"}, rf_wr_data, data);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    set_a(1'b0, 5'd0, 64'h0);
    set_b(1'b0, 5'd0, 64'h0);
    #1;
    chk("rst_wr_en", rf_wr_en, 1'b0);
    chk("rst_b_ready", b_ready, 1'b0);
    chk("rst_pending", b_pending, 2'd0);
    chk("rst_stall", stall_req, 1'b0);
    chk("rst_proto", proto_err, 1'b0);
    #11 reset_n = 1'b1;
    tick();
    chk("rel_b_ready", b_ready, 1'b1);
    chk("rel_wr_en", rf_wr_en, 1'b0);

    // A only, back-to-back
    set_a(1'b1, 5'd1, 64'h11);
    tick();
    chk_wr("a_x1", 1'b1, 5'd1, 64'h11);
    set_a(1'b1, 5'd2, 64'h22);
    tick();
    chk_wr("a_x2", 1'b1, 5'd2, 64'h22);
    chk("a_pending", b_pending, 2'd0);
    set_a(1'b0, 5'd0, 64'h0);
    tick();
    chk("a_idle", rf_wr_en, 1'b0);

    // B into idle slot: write appears two edges after the push
    set_b(1'b1, 5'd5, 64'hAB);
    tick();
    chk("b_nobypass", rf_wr_en, 1'b0);
    chk("b_pending1", b_pending, 2'd1);
    set_b(1'b0, 5'd0, 64'h0);
    tick();
    chk_wr("b_x5", 1'b1, 5'd5, 64'hAB);
    chk("b_pending0", b_pending, 2'd0);
    tick();
    chk("b_idle", rf_wr_en, 1'b0);

    // XZR discard from both ports
    set_a(1'b1, 5'd31, 64'hDEAD);
    tick();
    chk("xzr_a", rf_wr_en, 1'b0);
    set_a(1'b0, 5'd0, 64'h0);
    set_b(1'b1, 5'd31, 64'hBEEF);
    tick();
    chk("xzr_b_push", rf_wr_en, 1'b0);
    chk("xzr_b_pend1", b_pending, 2'd1);
    set_b(1'b0, 5'd0, 64'h0);
    tick();
    chk("xzr_b_pop", rf_wr_en, 1'b0);
    chk("xzr_b_pend0", b_pending, 2'd0);

    // Starvation: one entry loses four cycles to A, then the stall drains it
    set_a(1'b1, 5'd3, 64'h33);
    set_b(1'b1, 5'd7, 64'h77);
    tick();
    chk_wr("sv_a0", 1'b1, 5'd3, 64'h33);
    chk("sv_pend", b_pending, 2'd1);
    set_b(1'b0, 5'd0, 64'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("sv_nostall", stall_req, 1'b0);
      chk_wr("sv_a", 1'b1, 5'd3, 64'h33);
    end
    tick();
    chk("sv_stall_hi", stall_req, 1'b1);
    chk("sv_pend_hold", b_pending, 2'd1);
    set_a(1'b0, 5'd0, 64'h0);
    tick();
    chk_wr("sv_b_x7", 1'b1, 5'd7, 64'h77);
    chk("sv_stall_lo", stall_req, 1'b0);
    chk("sv_pend0", b_pending, 2'd0);
    chk("sv_proto", proto_err, 1'b0);

    // Full FIFO: third b_valid waits until a pop frees a slot
    set_a(1'b1, 5'd8, 64'h88);
    set_b(1'b1, 5'd9, 64'h99);
    tick();
    chk("full_rdy1", b_ready, 1'b1);
    set_b(1'b1, 5'd10, 64'hAA);
    tick();
    chk("full_pend2", b_pending, 2'd2);
    chk("full_rdy0", b_ready, 1'b0);
    set_b(1'b1, 5'd11, 64'hBB);
    tick();
    chk("full_hold", b_pending, 2'd2);
    chk("full_rdy0b", b_ready, 1'b0);
    chk_wr("full_a", 1'b1, 5'd8, 64'h88);
    set_a(1'b0, 5'd0, 64'h0);
    tick();
    chk_wr("full_x9", 1'b1, 5'd9, 64'h99);
    chk("full_pend1", b_pending, 2'd1);
    chk("full_rdy_back", b_ready, 1'b1);
    tick();
    chk_wr("full_x10", 1'b1, 5'd10, 64'hAA);
    chk("full_pend_swap", b_pending, 2'd1);
    set_b(1'b0, 5'd0, 64'h0);
    tick();
    chk_wr("full_x11", 1'b1, 5'd11, 64'hBB);
    chk("full_pend0", b_pending, 2'd0);

    // Protocol violation during STALL: A dropped, B written, proto_err sticky
    set_a(1'b1, 5'd20, 64'h2020);
    set_b(1'b1, 5'd12, 64'hC12);
    tick();
    set_b(1'b1, 5'd13, 64'hC13);
    tick();
    set_b(1'b0, 5'd0, 64'h0);
    tick();
    tick();
    tick();
    chk("pe_stall_hi", stall_req, 1'b1);
    chk("pe_pend2", b_pending, 2'd2);
    tick();
    chk_wr("pe_b_x12", 1'b1, 5'd12, 64'hC12);
    chk("pe_proto", proto_err, 1'b1);
    chk("pe_stall_lo", stall_req, 1'b0);
    chk("pe_pend1", b_pending, 2'd1);

    // Rebuild two entries with stall_req high, then reset mid-operation
    set_b(1'b1, 5'd14, 64'hC14);
    tick();
    chk_wr("rs_a", 1'b1, 5'd20, 64'h2020);
    set_b(1'b0, 5'd0, 64'h0);
    tick();
    tick();
    tick();
    chk("rs_stall_hi", stall_req, 1'b1);
    chk("rs_pend2", b_pending, 2'd2);
    chk("rs_proto_sticky", proto_err, 1'b1);
    set_a(1'b0, 5'd0, 64'h0);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_wr_en", rf_wr_en, 1'b0);
    chk("ar_wr_addr", rf_wr_addr, 5'd0);
    chk("ar_wr_data", rf_wr_data, 64'h0);
    chk("ar_stall", stall_req, 1'b0);
    chk("ar_b_ready", b_ready, 1'b0);
    chk("ar_pending", b_pending, 2'd0);
    chk("ar_proto", proto_err, 1'b0);
    tick();
    #2 reset_n = 1'b1;
    #1;
    chk("ar_rel_rdy0", b_ready, 1'b0);
    tick();
    chk("ar_rel_rdy1", b_ready, 1'b1);
    chk("ar_no_stale", rf_wr_en, 1'b0);
    chk("ar_rel_pend", b_pending, 2'd0);
    chk("ar_rel_stall", stall_req, 1'b0);
    tick();
    chk("ar_no_stale2", rf_wr_en, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
